gray_counter: RTL and testbench
===============================

# gray_counter

Registered Gray-code sequence generator that produces the 4-bit (parameterisable) Gray words consumed by the Gray-to-binary converter stage downstream. It keeps an internal binary count, advances it up or down on request, and presents the Gray encoding of the count with a valid/ready handshake. It supports synchronous load of a binary start value and flags wrap-around. Consecutive accepted words differ in exactly one bit, except across a load.

## Interface
Parameters:
- WIDTH, 4, bit width of count and Gray output (≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  request to generate the next code
- up  in  1  direction: 1 = increment, 0 = decrement; sampled with en
- load  in  1  synchronous load strobe, highest priority after rst
- load_bin  in  WIDTH  binary value loaded on load
- g  out  WIDTH  registered Gray word, g = cnt ^ (cnt >> 1)
- g_valid  out  1  g holds a word not yet accepted downstream
- g_ready  in  1  downstream accepts g when g_valid && g_ready
- wrap  out  1  one-cycle pulse, count wrapped on this step

## Operation
- Internal binary register cnt (WIDTH bits); g is always the registered Gray encoding of cnt, never combinational from inputs.
- Transfer = g_valid && g_ready in the same cycle.
- Per-cycle priority, evaluated at each rising edge:
  1. rst: cnt←0, g←0, g_valid←1, wrap←0.
  2. load: cnt←load_bin, g←gray(load_bin), g_valid←1, wrap←0; a pending unaccepted word is discarded; a simultaneous transfer still counts as accepted by downstream.
  3. g_valid=1 and no transfer: hold cnt, g, g_valid; en and up ignored; wrap←0.
  4. g_valid=1, transfer, en=1: step cnt (±1 mod 2^WIDTH per up), g_valid stays 1.
  5. g_valid=1, transfer, en=0: cnt held, g_valid←0.
  6. g_valid=0, en=1: step cnt, g_valid←1.
  7. g_valid=0, en=0: hold.
- Step arithmetic: modulo 2^WIDTH, no saturation. Up from all-ones gives 0. Down from 0 gives all-ones.
- wrap←1 for exactly the cycle after a step crossing the boundary (up: max→0, down: 0→max); otherwise 0. A load never raises wrap, even when load_bin is 0 or max.
- Effective state machine on g_valid: EMPTY (g_valid=0) / FULL (g_valid=1).
  - FULL→EMPTY only via rule 5.
  - EMPTY→FULL via rule 6 or load.
  - Reset enters FULL with word 0, so the first word downstream is 0000.

## Timing
- Latency: en (with transfer or EMPTY) at edge N → new g visible after edge N, i.e. one cycle.
- Sustained throughput: one word per clock with en=1 and g_ready=1.
- Reset values: g=0, g_valid=1, wrap=0, cnt=0.
- g and wrap change only on clock edges; g is stable while g_valid=1 and g_ready=0.
- Reset mid-operation overrides load, en and handshake in that cycle; the next cycle presents g=0, g_valid=1.
- Direction may change on any step; each step uses up as sampled at that edge.

## Test plan
- Up count: rst, then en=1, up=1, g_ready=1 for 16 cycles → g = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with wrap=1 for one cycle. Downstream converter output = 0..15, 0.
- Down count: rst, en=1, up=0, g_ready=1 → g = 0000, then 1000 with wrap=1, then 1001, 1011; each accepted pair differs in one bit.
- Backpressure: at g=0011, g_ready=0 for 3 cycles with en=1 → g holds 0011, g_valid=1. On g_ready=1 → g=0010 next cycle.
- Drain/idle: g_ready=1, en=0 at g=0110 → g_valid=0 next cycle, g holds 0110. en=1 two cycles later → g=0111, g_valid=1.
- Load: load=1, load_bin=1010 while g_ready=0, g=0001 → next cycle g=1111, g_valid=1, wrap=0. Load with load_bin=0000 gives wrap=0.
- Reset mid-run: rst=1 at g=1101 with en=1, load=1 → next cycle g=0000, g_valid=1, wrap=0.

Source files
------------

// File: rtl/gray_counter.sv
// Registered Gray-code sequence generator with valid/ready output, up/down stepping,
// synchronous binary load and a one-cycle wrap pulse.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] g,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             wrap
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             xfer;
  logic             step;
  logic             crosses;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    xfer    = (state == FULL) && g_ready;
    // A FULL word may only be replaced once it has been accepted.
    step    = en && ((state == EMPTY) || xfer);
    nxt     = up ? cnt + 1'b1 : cnt - 1'b1;
    crosses = up ? (cnt == '1) : (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      g     <= '0;
      state <= FULL;
      wrap  <= 1'b0;
    end else if (load) begin
      cnt   <= load_bin;
      g     <= to_gray(load_bin);
      state <= FULL;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (step) begin
        cnt   <= nxt;
        g     <= to_gray(nxt);
        state <= FULL;
        wrap  <= crosses;
      end else if (xfer) begin
        state <= EMPTY;
      end
    end
  end

  assign g_valid = (state == FULL);

endmodule

// File: tb/tb_gray_counter.sv
// Randomized bench for gray_counter against an integer-arithmetic reference model.
module tb_gray_counter;

  localparam int unsigned W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, up, load, g_ready;
  logic [W-1:0] load_bin;
  logic [W-1:0] g;
  logic         g_valid, wrap;

  int checks = 0;
  int failures = 0;

  // reference model state
  int  m_cnt = 0;
  bit  m_valid = 1'b1;
  bit  m_wrap = 1'b0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .g(g), .g_valid(g_valid), .g_ready(g_ready), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int gray_of(input int c);
    return c ^ (c >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cycle(input bit r, input bit l, input int lb, input bit e,
                       input bit u, input bit rd);
    int  old_gray;
    bit  stepped;
    rst = r; load = l; load_bin = W'(lb); en = e; up = u; g_ready = rd;
    old_gray = gray_of(m_cnt);
    stepped = 1'b0;
    if (r) begin
      m_cnt = 0; m_valid = 1'b1; m_wrap = 1'b0;
    end else if (l) begin
      m_cnt = lb; m_valid = 1'b1; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (e && (!m_valid || rd)) begin
        m_cnt = u ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
        m_wrap = u ? (m_cnt == 0) : (m_cnt == M - 1);
        m_valid = 1'b1;
        stepped = 1'b1;
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("g", int'(g), gray_of(m_cnt));
    check("g_valid", int'(g_valid), int'(m_valid));
    check("wrap", int'(wrap), int'(m_wrap));
    if (stepped)
      check("one_bit_change", $countones(int'(g) ^ old_gray), 1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_bin = '0; en = 1'b0; up = 1'b0; g_ready = 1'b0;
    @(negedge clk);

    // full up-count sequence including wrap back to 0
    cycle(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < M + 2; i++) cycle(0, 0, 0, 1, 1, 1);

    // down from 0 wraps to max
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 1);

    // backpressure hold, then drain and idle
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1, 0);

    // loads at the boundaries never raise wrap
    cycle(0, 1, 10, 1, 1, 0);
    cycle(0, 1, 0, 1, 0, 1);
    cycle(0, 1, M - 1, 1, 1, 1);
    cycle(0, 0, 0, 1, 1, 1);

    // reset overriding load and en
    cycle(1, 1, 5, 1, 1, 1);

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 8), int'($urandom_range(M - 1)),
            ($urandom_range(99) < 70), $urandom_range(1) == 1, ($urandom_range(99) < 70));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
